subtractor: RTL and testbench

Registered N-bit binary subtractor with borrow-in and borrow-out. It computes `i_a − i_b − i_carry` in two's-complement / modular arithmetic and presents the difference and the borrow on registered outputs one clock later. It is a leaf arithmetic block. Borrow ports allow several instances to be chained into wider subtractions.

---
 rtl/arith_pkg.sv | 7 +
 rtl/full_subtractor.sv | 22 ++
 rtl/subtractor.sv | 58 +++++
 tb/tb_subtractor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the leaf arithmetic blocks.
//   SUB_DEFAULT_W : default operand/result width of the subtractor.
package arith_pkg;

  localparam int SUB_DEFAULT_W = 8;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor, purely combinational.
//   i_a      : minuend bit
//   i_b      : subtrahend bit
//   i_borrow : borrow into this bit position
//   o_diff   : difference bit, a ^ b ^ borrow
//   o_borrow : borrow out, set when a < b + borrow for this bit
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_borrow,
  output logic o_diff,
  output logic o_borrow
);

  logic ab_x;

  assign ab_x     = i_a ^ i_b;
  assign o_diff   = ab_x ^ i_borrow;
  // Borrow when b beats a outright, or when a == b and a borrow comes in.
  assign o_borrow = (~i_a & i_b) | (~ab_x & i_borrow);

endmodule : full_subtractor

// File: rtl/subtractor.sv
// Registered N-bit unsigned subtractor with borrow-in and borrow-out.
// Computes (i_a - i_b - i_carry) mod 2^N through an LSB-first ripple chain
// of full subtractors and registers {borrow, difference} every cycle.
// Borrow ports let several instances be chained into a wider subtraction.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears both outputs
//   i_a     : N-bit minuend
//   i_b     : N-bit subtrahend
//   i_carry : borrow-in, subtracts an extra 1 when set
//   o_out   : registered N-bit difference, one cycle latency
//   o_carry : registered borrow-out, set when i_a < i_b + i_carry
module subtractor
  import arith_pkg::*;
#(
  parameter int N = SUB_DEFAULT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry,
  output logic [N-1:0] o_out,
  output logic         o_carry
);

  logic [N:0]   borrow;
  logic [N-1:0] diff_d;
  logic [N:0]   res_d;
  logic [N:0]   res_q;

  // Stage p0: combinational ripple chain, borrow[k] feeds bit k.
  assign borrow[0] = i_carry;

  for (genvar k = 0; k < N; k++) begin : g_bit
    full_subtractor u_fs (
      .i_a      (i_a[k]),
      .i_b      (i_b[k]),
      .i_borrow (borrow[k]),
      .o_diff   (diff_d[k]),
      .o_borrow (borrow[k+1])
    );
  end

  assign res_d = {borrow[N], diff_d};

  // Stage p1: output register, loads every cycle; reset discards in-flight result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign o_out   = res_q[N-1:0];
  assign o_carry = res_q[N];

endmodule : subtractor

// File: tb/tb_subtractor.sv
module tb_subtractor;

  logic        clk;
  logic        rst_n;

  logic [7:0]  a8, b8;
  logic        c8;
  logic [7:0]  out8;
  logic        co8;

  logic        a1, b1, c1;
  logic        out1;
  logic        co1;

  logic [15:0] a16, b16;
  logic        c16;
  logic [15:0] out16;
  logic        co16;

  int n_checks;
  int n_pass;

  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [16:0] q16[$];

  subtractor #(.N(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a8), .i_b(b8), .i_carry(c8),
    .o_out(out8), .o_carry(co8)
  );

  subtractor #(.N(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a1), .i_b(b1), .i_carry(c1),
    .o_out(out1), .o_carry(co1)
  );

  subtractor #(.N(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a16), .i_b(b16), .i_carry(c16),
    .o_out(out16), .o_carry(co16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs from the previous cycle, then drive this cycle's operands
  // and queue the reference result {borrow, diff} = {0,a} - {0,b} - cin.
  task automatic step(input logic rst_in,
                      input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                      input logic ia1, input logic ib1, input logic ic1,
                      input logic [15:0] ia16, input logic [15:0] ib16, input logic ic16);
    logic [8:0]  e8;
    logic [1:0]  e1;
    logic [16:0] e16;
    @(negedge clk);
    if (q8.size() > 0)  check("n8",  32'({co8, out8}),   32'(q8.pop_front()));
    if (q1.size() > 0)  check("n1",  32'({co1, out1}),   32'(q1.pop_front()));
    if (q16.size() > 0) check("n16", 32'({co16, out16}), 32'(q16.pop_front()));
    rst_n = rst_in;
    a8 = ia8;   b8 = ib8;   c8 = ic8;
    a1 = ia1;   b1 = ib1;   c1 = ic1;
    a16 = ia16; b16 = ib16; c16 = ic16;
    e8  = {1'b0, ia8}  - {1'b0, ib8}  - {8'd0, ic8};
    e1  = {1'b0, ia1}  - {1'b0, ib1}  - {1'b0, ic1};
    e16 = {1'b0, ia16} - {1'b0, ib16} - {16'd0, ic16};
    q8.push_back(rst_in ? e8 : 9'd0);
    q1.push_back(rst_in ? e1 : 2'd0);
    q16.push_back(rst_in ? e16 : 17'd0);
  endtask

  // Drive the 8-bit instance with chosen operands, the others with random ones.
  task automatic step8(input logic rst_in, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic);
    step(rst_in, ia, ib, ic,
         1'($urandom), 1'($urandom), 1'($urandom),
         16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [2:0] combo;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0;

    // Reset held with live operands, then released.
    step8(1'b0, 8'd10, 8'd5, 1'b0);
    step8(1'b0, 8'd10, 8'd5, 1'b0);
    step8(1'b1, 8'd10, 8'd5, 1'b0);

    // Back-to-back basic sequence.
    step8(1'b1, 8'd10, 8'd5, 1'b0);
    step8(1'b1, 8'd8, 8'd10, 1'b0);
    step8(1'b1, 8'd15, 8'd8, 1'b0);

    // Borrow-in boundaries.
    step8(1'b1, 8'd0, 8'd0, 1'b1);
    step8(1'b1, 8'd0, 8'd255, 1'b1);
    step8(1'b1, 8'd255, 8'd255, 1'b0);
    step8(1'b1, 8'd255, 8'd0, 1'b1);

    // Reset mid-stream, then resume.
    step8(1'b1, 8'd8, 8'd10, 1'b0);
    step8(1'b0, 8'd8, 8'd10, 1'b0);
    step8(1'b1, 8'd20, 8'd3, 1'b0);

    // N=1 exhaustive and N=16 spot checks alongside the 8-bit instance.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
           combo[2], combo[1], combo[0],
           16'h0000, 16'h0001, 1'b0);
    end
    step(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 1'b0);
    step(1'b1, 8'd1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
    step(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);

    // Random sweep on all instances.
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Drain the last queued result.
    step8(1'b1, 8'd0, 8'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_subtractor
